// File: rtl/note_highway.sv
// note_highway: falling-note engine for the VGA rhythm game.
// Holds SLOTS notes per lane, spawns them from a writable beat pattern,
// scrolls them on frame_tick, judges presses and drives per-lane pixel flags.
// Build option: NOTE_HIGHWAY_SCORE_EN enables hit judging, hit_ok and score;
// without it hit_btn is ignored, hit_ok/score read 0 and miss means retirement only.
module note_highway #(
   parameter int unsigned LANES     = 3,
   parameter int unsigned SLOTS     = 4,
   parameter int unsigned PAT_DEPTH = 8,
   parameter int unsigned LANE_W    = 200,
   parameter int unsigned LANE_GAP  = 20,
   parameter int unsigned BAR_HALF  = 10,
   parameter int unsigned SPAWN_Y   = 0,
   parameter int unsigned HIT_Y     = 400,
   parameter int unsigned HIT_WIN   = 16,
   parameter int unsigned STEP      = 1,
   parameter int unsigned Y_MAX     = 479
) (
   input  logic                         board_clk,
   input  logic                         reset,
   input  logic                         restart,
   input  logic                         frame_tick,
   input  logic                         beat_tick,
   input  logic                         pat_wr_en,
   input  logic [$clog2(PAT_DEPTH)-1:0] pat_wr_addr,
   input  logic [LANES-1:0]             pat_wr_data,
   input  logic [LANES-1:0]             hit_btn,
   input  logic [9:0]                   pix_x,
   input  logic [9:0]                   pix_y,
   input  logic                         pix_valid,
   output logic [LANES-1:0]             pix_on,
   output logic [LANES-1:0]             hit_ok,
   output logic [LANES-1:0]             miss,
   output logic                         spawn_drop,
   output logic [7:0]                   score,
   output logic [$clog2(PAT_DEPTH)-1:0] pat_idx
);

   localparam int unsigned AW      = $clog2(PAT_DEPTH);
   localparam logic [10:0] STEP_W  = 11'(STEP);
   localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
   localparam logic [10:0] BAR_W   = 11'(BAR_HALF);
   localparam logic [9:0]  SPAWN_W = 10'(SPAWN_Y);

   logic [SLOTS-1:0] vld_q [LANES];
   logic [SLOTS-1:0] vld_d [LANES];
   logic [9:0]       y_q   [LANES][SLOTS];
   logic [9:0]       y_d   [LANES][SLOTS];
   logic [AW-1:0]    idx_q, idx_d;
   logic [LANES-1:0] miss_q, miss_d;
   logic [LANES-1:0] pix_q, pix_d;
   logic             drop_q, drop_d;

   // Pattern store has no reset; configuration-time contents are zero.
   logic [LANES-1:0] pat_mem [PAT_DEPTH];
   logic [LANES-1:0] pat_rd;

   logic             found;
   logic [10:0]      ny;

   logic [31:0]      px_w;
   logic [10:0]      py_w;
   logic [31:0]      x_lo;
   logic             in_x;
   logic [10:0]      yb;

`ifdef NOTE_HIGHWAY_SCORE_EN
   logic [LANES-1:0] hit_ok_q, hit_ok_d;
   logic [7:0]       score_q, score_d;
   logic [7:0]       hits;
   logic [8:0]       sc_sum;
   logic             hfound;
   logic [31:0]      yi;
`endif

   assign pat_rd = pat_mem[idx_q];
   assign px_w   = {22'd0, pix_x};
   assign py_w   = {1'b0, pix_y};

   // Pattern RAM write port; a same-edge read of that address sees the old entry.
   always_ff @(posedge board_clk) begin
      if (pat_wr_en) begin
         pat_mem[pat_wr_addr] <= pat_wr_data;
      end
   end

   // Game-state next values: hit judging, then scrolling, then spawning, all from cycle-start state.
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         vld_d[l] = vld_q[l];
         for (int unsigned s = 0; s < SLOTS; s++) begin
            y_d[l][s] = y_q[l][s];
         end
      end
      miss_d = '0;
      drop_d = 1'b0;
      idx_d  = idx_q;
      found  = 1'b0;
      ny     = '0;
`ifdef NOTE_HIGHWAY_SCORE_EN
      hit_ok_d = '0;
      score_d  = score_q;
      hits     = '0;
      sc_sum   = '0;
      hfound   = 1'b0;
      yi       = '0;
`endif
      if (restart) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            vld_d[l] = '0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
               y_d[l][s] = '0;
            end
         end
         idx_d = '0;
`ifdef NOTE_HIGHWAY_SCORE_EN
         score_d = '0;
`endif
      end else begin
         for (int unsigned l = 0; l < LANES; l++) begin
`ifdef NOTE_HIGHWAY_SCORE_EN
            if (hit_btn[l]) begin
               hfound = 1'b0;
               for (int unsigned s = 0; s < SLOTS; s++) begin
                  yi = {22'd0, y_q[l][s]};
                  if (!hfound && vld_q[l][s] &&
                      (yi + HIT_WIN >= HIT_Y) && (yi <= HIT_Y + HIT_WIN)) begin
                     hfound      = 1'b1;
                     vld_d[l][s] = 1'b0;
                  end
               end
               if (hfound) begin
                  hit_ok_d[l] = 1'b1;
                  hits        = hits + 8'd1;
               end else begin
                  miss_d[l] = 1'b1;
               end
            end
`endif
            // vld_d here already excludes slots consumed by a hit this cycle
            if (frame_tick) begin
               for (int unsigned s = 0; s < SLOTS; s++) begin
                  if (vld_d[l][s]) begin
                     ny = {1'b0, y_q[l][s]} + STEP_W;
                     if (ny > YMAX_W) begin
                        vld_d[l][s] = 1'b0;
                        miss_d[l]   = 1'b1;
                     end else begin
                        y_d[l][s] = ny[9:0];
                     end
                  end
               end
            end
            // only slots free at cycle start may take a new note
            if (beat_tick && pat_rd[l]) begin
               found = 1'b0;
               for (int unsigned s = 0; s < SLOTS; s++) begin
                  if (!found && !vld_q[l][s]) begin
                     found       = 1'b1;
                     vld_d[l][s] = 1'b1;
                     y_d[l][s]   = SPAWN_W;
                  end
               end
               if (!found) begin
                  drop_d = 1'b1;
               end
            end
         end
         if (beat_tick) begin
            idx_d = idx_q + AW'(1);
         end
`ifdef NOTE_HIGHWAY_SCORE_EN
         sc_sum  = {1'b0, score_q} + {1'b0, hits};
         score_d = sc_sum[8] ? 8'hFF : sc_sum[7:0];
`endif
      end
   end

   // Pixel flags from cycle-start slot state: lane column test plus bar overlap test.
   always_comb begin
      pix_d = '0;
      x_lo  = '0;
      in_x  = 1'b0;
      yb    = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         x_lo = l * (LANE_W + LANE_GAP);
         in_x = pix_valid && (px_w >= x_lo) && (px_w <= x_lo + LANE_W - 32'd1);
         for (int unsigned s = 0; s < SLOTS; s++) begin
            yb = {1'b0, y_q[l][s]};
            if (in_x && vld_q[l][s] && (py_w + BAR_W >= yb) && (py_w <= yb + BAR_W)) begin
               pix_d[l] = 1'b1;
            end
         end
      end
   end

   // Game-state and pulse registers.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            vld_q[l] <= '0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
               y_q[l][s] <= '0;
            end
         end
         idx_q  <= '0;
         miss_q <= '0;
         drop_q <= 1'b0;
         pix_q  <= '0;
      end else begin
         for (int unsigned l = 0; l < LANES; l++) begin
            vld_q[l] <= vld_d[l];
            for (int unsigned s = 0; s < SLOTS; s++) begin
               y_q[l][s] <= y_d[l][s];
            end
         end
         idx_q  <= idx_d;
         miss_q <= miss_d;
         drop_q <= drop_d;
         pix_q  <= restart ? '0 : pix_d;
      end
   end

`ifdef NOTE_HIGHWAY_SCORE_EN
   // Hit pulse and score registers.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         hit_ok_q <= '0;
         score_q  <= '0;
      end else begin
         hit_ok_q <= hit_ok_d;
         score_q  <= score_d;
      end
   end

   assign hit_ok = hit_ok_q;
   assign score  = score_q;
`else
   logic unused_hit_btn;
   assign unused_hit_btn = ^hit_btn;
   assign hit_ok = '0;
   assign score  = '0;
`endif

   assign pix_on     = pix_q;
   assign miss       = miss_q;
   assign spawn_drop = drop_q;
   assign pat_idx    = idx_q;

endmodule

// File: tb/tb_note_highway.sv
// Bench for note_highway: stimulus table, hand-written corner sequences and a
// randomized phase, all compared against a note-list model of the game rules.
module tb_note_highway;
   localparam int L = 3;
   localparam int S = 4;
   localparam int D = 8;
`ifdef NOTE_HIGHWAY_SCORE_EN
   localparam bit SCORE_EN = 1'b1;
`else
   localparam bit SCORE_EN = 1'b0;
`endif

   logic       board_clk = 1'b0;
   logic       reset, restart, frame_tick, beat_tick, pat_wr_en;
   logic [2:0] pat_wr_addr, pat_wr_data, hit_btn;
   logic [9:0] pix_x, pix_y;
   logic       pix_valid;
   logic [2:0] pix_on, hit_ok, miss, pat_idx;
   logic       spawn_drop;
   logic [7:0] score;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 board_clk = ~board_clk;

   note_highway #(.LANES(3), .SLOTS(4), .PAT_DEPTH(8)) dut (
      .board_clk(board_clk), .reset(reset), .restart(restart),
      .frame_tick(frame_tick), .beat_tick(beat_tick),
      .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
      .hit_btn(hit_btn), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .pix_on(pix_on), .hit_ok(hit_ok), .miss(miss), .spawn_drop(spawn_drop),
      .score(score), .pat_idx(pat_idx));

   // model: each lane is a set of notes, position -1 means empty
   int         my [L][S];
   int         msc, midx;
   logic [2:0] mpat [D];
   logic [2:0] e_pix, e_hit, e_miss;
   logic       e_drop;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int l = 0; l < L; l++) for (int s = 0; s < S; s++) my[l][s] = -1;
      msc = 0; midx = 0;
      e_pix = '0; e_hit = '0; e_miss = '0; e_drop = 1'b0;
   endfunction

   function automatic void model_step();
      logic [2:0] rd;
      bit free0 [L][S];
      bit got;
      rd = mpat[midx];
      if (pat_wr_en) mpat[pat_wr_addr] = pat_wr_data;
      e_hit = '0; e_miss = '0; e_drop = 1'b0; e_pix = '0;
      if (restart) begin
         for (int l = 0; l < L; l++) for (int s = 0; s < S; s++) my[l][s] = -1;
         msc = 0; midx = 0;
         return;
      end
      for (int l = 0; l < L; l++)
         for (int s = 0; s < S; s++)
            if (pix_valid && pix_x >= l*220 && pix_x < l*220 + 200 && my[l][s] >= 0 &&
                pix_y + 10 >= my[l][s] && pix_y <= my[l][s] + 10)
               e_pix[l] = 1'b1;
      for (int l = 0; l < L; l++) for (int s = 0; s < S; s++) free0[l][s] = (my[l][s] < 0);
      if (SCORE_EN) begin
         for (int l = 0; l < L; l++) begin
            if (hit_btn[l]) begin
               got = 0;
               for (int s = 0; s < S; s++)
                  if (!got && my[l][s] >= 0 && my[l][s] - 400 <= 16 && 400 - my[l][s] <= 16) begin
                     got = 1; my[l][s] = -1;
                  end
               if (got) begin
                  e_hit[l] = 1'b1;
                  msc = (msc < 255) ? msc + 1 : 255;
               end else e_miss[l] = 1'b1;
            end
         end
      end
      if (frame_tick)
         for (int l = 0; l < L; l++)
            for (int s = 0; s < S; s++)
               if (my[l][s] >= 0) begin
                  my[l][s] = my[l][s] + 1;
                  if (my[l][s] > 479) begin my[l][s] = -1; e_miss[l] = 1'b1; end
               end
      if (beat_tick) begin
         for (int l = 0; l < L; l++)
            if (rd[l]) begin
               got = 0;
               for (int s = 0; s < S; s++)
                  if (!got && free0[l][s]) begin got = 1; my[l][s] = 0; end
               if (!got) e_drop = 1'b1;
            end
         midx = (midx + 1) % D;
      end
   endfunction

   function automatic void check_model();
      chk("pix_on", 32'(pix_on), 32'(e_pix));
      chk("hit_ok", 32'(hit_ok), 32'(e_hit));
      chk("miss", 32'(miss), 32'(e_miss));
      chk("spawn_drop", 32'(spawn_drop), 32'(e_drop));
      chk("score", 32'(score), 32'(msc));
      chk("pat_idx", 32'(pat_idx), 32'(midx));
   endfunction

   task automatic tick();
      @(posedge board_clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle();
      restart = 0; frame_tick = 0; beat_tick = 0; pat_wr_en = 0; hit_btn = '0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [2:0] d);
      pat_wr_en = 1; pat_wr_addr = a; pat_wr_data = d;
      tick();
      pat_wr_en = 0;
   endtask

   task automatic probe(input string name, input int x, input int y, input logic [2:0] exp);
      pix_x = 10'(x); pix_y = 10'(y); pix_valid = 1;
      tick();
      chk(name, 32'(pix_on), 32'(exp));
      pix_valid = 0;
   endtask

   typedef struct {
      logic       bt, we;
      logic [2:0] wa, wd;
      int         px, py;
      logic       pv;
      logic [2:0] e_pix;
      logic       e_drop;
      logic [2:0] e_idx;
   } vec_t;

   vec_t tv [8];
   logic [2:0] early;
   bit sat_seen;
   logic [2:0] hb;

   initial begin
      tv[0] = '{0, 1, 3'd0, 3'b101,   0,  0, 0, 3'b000, 0, 3'd0};
      tv[1] = '{1, 0, 3'd0, 3'b000,   0,  0, 0, 3'b000, 0, 3'd1};
      tv[2] = '{0, 0, 3'd0, 3'b000,  10,  5, 1, 3'b001, 0, 3'd1};
      tv[3] = '{0, 0, 3'd0, 3'b000,  10, 11, 1, 3'b000, 0, 3'd1};
      tv[4] = '{0, 0, 3'd0, 3'b000, 450, 10, 1, 3'b100, 0, 3'd1};
      tv[5] = '{0, 0, 3'd0, 3'b000,  10, 10, 0, 3'b000, 0, 3'd1};
      tv[6] = '{0, 0, 3'd0, 3'b000, 200,  5, 1, 3'b000, 0, 3'd1};
      tv[7] = '{0, 0, 3'd0, 3'b000, 199,  0, 1, 3'b001, 0, 3'd1};

      for (int a = 0; a < D; a++) mpat[a] = '0;
      idle(); pat_wr_addr = '0; pat_wr_data = '0;
      pix_x = '0; pix_y = '0; pix_valid = 0;
      reset = 0;
      #1 reset = 1;
      #1;
      chk("rst_pix", 32'(pix_on), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_idx", 32'(pat_idx), 0);
      chk("rst_pulses", 32'({hit_ok, miss, spawn_drop}), 0);
      @(posedge board_clk); #1 reset = 0;
      model_reset();

      // table: pattern entry 0 = 101, one beat, pixel probes
      for (int a = 1; a < D; a++) wr(3'(a), 3'b000);
      for (int i = 0; i < 8; i++) begin
         idle();
         beat_tick = tv[i].bt; pat_wr_en = tv[i].we;
         pat_wr_addr = tv[i].wa; pat_wr_data = tv[i].wd;
         pix_x = 10'(tv[i].px); pix_y = 10'(tv[i].py); pix_valid = tv[i].pv;
         tick();
         chk($sformatf("tv%0d_pix", i), 32'(pix_on), 32'(tv[i].e_pix));
         chk($sformatf("tv%0d_drop", i), 32'(spawn_drop), 32'(tv[i].e_drop));
         chk($sformatf("tv%0d_idx", i), 32'(pat_idx), 32'(tv[i].e_idx));
      end
      idle(); pix_valid = 0;

      // retirement after 480 frames
      early = '0;
      for (int k = 1; k <= 480; k++) begin
         frame_tick = 1;
         tick();
         if (k < 480) early = early | miss;
      end
      chk("retire_miss", 32'(miss), 32'(3'b101));
      chk("early_miss", 32'(early), 0);
      idle();
      probe("retired_pix", 10, 475, 3'b000);

      // hit and press-miss
      restart = 1; tick(); restart = 0;
      chk("restart_idx", 32'(pat_idx), 0);
      for (int a = 0; a < D; a++) wr(3'(a), 3'b001);
      beat_tick = 1; tick(); beat_tick = 0;
      frame_tick = 1; repeat (27) tick(); frame_tick = 0;
      beat_tick = 1; tick(); beat_tick = 0;
      frame_tick = 1; repeat (390) tick(); frame_tick = 0;
      hit_btn = 3'b001; tick(); hit_btn = '0;
      chk("hit390_ok", 32'(hit_ok), SCORE_EN ? 32'd1 : 32'd0);
      chk("hit390_miss", 32'(miss), 0);
      chk("hit390_score", 32'(score), SCORE_EN ? 32'd1 : 32'd0);
      probe("hit390_cleared", 10, 390, SCORE_EN ? 3'b000 : 3'b001);
      hit_btn = 3'b001; tick(); hit_btn = '0;
      chk("press417_miss", 32'(miss), SCORE_EN ? 32'd1 : 32'd0);
      chk("press417_ok", 32'(hit_ok), 0);
      chk("press417_score", 32'(score), SCORE_EN ? 32'd1 : 32'd0);

      // lane full, drop and index wrap; pattern survives restart
      restart = 1; tick(); restart = 0;
      probe("after_restart_pix", 10, 0, 3'b000);
      pix_x = 10; pix_y = 0; pix_valid = 1;
      for (int b = 1; b <= 5; b++) begin
         beat_tick = 1; tick();
         if (b == 2) chk("pattern_kept_pix", 32'(pix_on), 1);
         chk($sformatf("beat%0d_drop", b), 32'(spawn_drop), (b == 5) ? 32'd1 : 32'd0);
      end
      chk("beat5_idx", 32'(pat_idx), 5);
      repeat (8) tick();
      chk("wrap_idx", 32'(pat_idx), 5);
      idle(); pix_valid = 0;

      // hit, frame and beat in one cycle with the lane full
      restart = 1; tick(); restart = 0;
      beat_tick = 1; repeat (4) tick(); beat_tick = 0;
      frame_tick = 1; repeat (400) tick();
      hit_btn = 3'b001; beat_tick = 1; tick(); idle();
      chk("same_hit", 32'(hit_ok), SCORE_EN ? 32'd1 : 32'd0);
      chk("same_drop", 32'(spawn_drop), 1);
      chk("same_score", 32'(score), SCORE_EN ? 32'd1 : 32'd0);
      chk("same_miss", 32'(miss), 0);
      probe("same_adv401", 10, 391, 3'b001);
      probe("same_none400", 10, 390, 3'b000);
      beat_tick = 1; tick(); beat_tick = 0;
      chk("freed_slot_drop", 32'(spawn_drop), SCORE_EN ? 32'd0 : 32'd1);

      // restart beats every simultaneous event
      restart = 1; frame_tick = 1; beat_tick = 1; hit_btn = 3'b111; tick(); idle();
      chk("restart_score", 32'(score), 0);
      chk("restart_idx2", 32'(pat_idx), 0);
      chk("restart_pulses", 32'({hit_ok, miss, spawn_drop}), 0);
      probe("restart_empty", 10, 401, 3'b000);

      // score saturation: all lanes, press whenever a note sits on the hit line
      for (int a = 0; a < D; a++) wr(3'(a), 3'b111);
      restart = 1; tick(); restart = 0;
      sat_seen = 0;
      for (int c = 0; c < 90 * 104; c++) begin
         frame_tick = 1;
         beat_tick = (c % 104 == 0);
         hb = '0;
         for (int l = 0; l < L; l++)
            for (int s = 0; s < S; s++)
               if (my[l][s] == 400) hb[l] = 1'b1;
         hit_btn = hb;
         if (hb != 0 && msc == 255 && !sat_seen) begin
            tick();
            sat_seen = 1;
            chk("sat_hit", 32'(hit_ok), 32'(hb));
            chk("sat_hold", 32'(score), 255);
         end else tick();
      end
      idle();
      chk("sat_final", 32'(score), SCORE_EN ? 32'd255 : 32'd0);

      // async reset mid-frame
      restart = 1; tick(); restart = 0;
      beat_tick = 1; tick(); beat_tick = 0;
      probe("pre_reset_pix", 10, 0, 3'b001);
      pix_valid = 1;
      #2 reset = 1;
      #1;
      chk("async_pix", 32'(pix_on), 0);
      chk("async_idx", 32'(pat_idx), 0);
      chk("async_score", 32'(score), 0);
      @(posedge board_clk); #1 reset = 0;
      model_reset();
      pix_valid = 0;

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         restart = ($urandom_range(0, 999) == 0);
         frame_tick = $urandom_range(0, 1) == 1;
         beat_tick = ($urandom_range(0, 11) == 0);
         pat_wr_en = ($urandom_range(0, 7) == 0);
         pat_wr_addr = 3'($urandom);
         pat_wr_data = 3'($urandom);
         hb = '0;
         for (int l = 0; l < L; l++) begin
            if ($urandom_range(0, 7) == 0) hb[l] = 1'b1;
            for (int s = 0; s < S; s++)
               if (my[l][s] >= 384 && my[l][s] <= 416 && $urandom_range(0, 3) == 0) hb[l] = 1'b1;
         end
         hit_btn = hb;
         pix_x = 10'($urandom_range(0, 639));
         pix_y = 10'($urandom_range(0, 479));
         pix_valid = ($urandom_range(0, 7) != 0);
         tick();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/note_highway.md
# note_highway

Parametrised falling-note engine for the VGA rhythm game. It holds up to SLOTS active notes per lane and spawns them from a writable beat pattern. It scrolls the notes down on a frame tick, judges player presses against a hit window, keeps the score, and produces per-lane pixel-on flags for the colour mux in front of the VGA output registers. It sits between the hvsync_generator counters and the top-level vga_r/g/b registers, fully synchronous to board_clk.

## Interface
- LANES, 3, number of note lanes
- SLOTS, 4, concurrent notes per lane
- PAT_DEPTH, 8, pattern entries (power of two)
- LANE_W, 200, lane width in pixels
- LANE_GAP, 20, gap between lanes in pixels
- BAR_HALF, 10, half-height of a note bar
- SPAWN_Y, 0, y given to a newly spawned note
- HIT_Y, 400, y centre of the hit line
- HIT_WIN, 16, accepted distance |y-HIT_Y|
- STEP, 1, pixels advanced per frame_tick
- Y_MAX, 479, last visible row; a note is retired beyond it
- board_clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- restart  in  1  sync clear of game state (pattern RAM kept)
- frame_tick  in  1  one-cycle pulse, advance notes
- beat_tick  in  1  one-cycle pulse, spawn from pattern
- pat_wr_en  in  1  pattern RAM write strobe
- pat_wr_addr  in  clog2(PAT_DEPTH)  write address
- pat_wr_data  in  LANES  lane-spawn mask
- hit_btn  in  LANES  one-cycle debounced press pulses
- pix_x, pix_y  in  10 each  current pixel
- pix_valid  in  1  inDisplayArea
- pix_on  out  LANES  registered lane pixel flags
- hit_ok  out  LANES  one-cycle hit pulse
- miss  out  LANES  one-cycle miss pulse
- spawn_drop  out  1  one-cycle pulse, spawn lost (lane full)
- score  out  8  hit count, saturating
- pat_idx  out  clog2(PAT_DEPTH)  next pattern entry

## Operation
- Slot state: valid bit plus 10-bit y. Reset or restart: all slots invalid, y=0, pat_idx=0, score=0, all pulse outputs 0, pix_on=0. Pattern RAM is not reset; its initial content is all zeros.
- Per-cycle evaluation order, all on slot state at cycle start:
  1. Hit: a hit_btn[l] pulse looks for valid lane-l slots with |y-HIT_Y| ≤ HIT_WIN.
     - Match: the lowest-index matching slot is cleared, hit_ok[l] pulses, and score increments (255 holds).
     - No match: miss[l] pulses and score is unchanged.
  2. Advance: on frame_tick every surviving valid slot gets y+STEP, computed 11 bits wide. If the result is > Y_MAX the slot is invalidated and miss[l] pulses. A single pulse covers multiple retirements, hits and press-misses in the same lane and cycle.
  3. Spawn: on beat_tick, read entry pat_idx. For each set bit l, the lowest-index slot in lane l that was free at cycle start gets y=SPAWN_Y and valid=1. That slot is not advanced in the same cycle.
     - No free slot: spawn_drop pulses and the note is lost.
     - pat_idx increments, wrapping from PAT_DEPTH-1 to 0.
- Pattern write happens on the same edge as a read. A read of the written address returns the old data.
- Pixel: pix_on[l] is registered high when all of these hold:
  - pix_valid;
  - l*(LANE_W+LANE_GAP) ≤ pix_x ≤ l*(LANE_W+LANE_GAP)+LANE_W-1;
  - some valid lane-l slot satisfies pix_y+BAR_HALF ≥ y and pix_y ≤ y+BAR_HALF, both sides 11-bit, so there is no wrap near row 0.
- restart takes priority over every tick and press in the same cycle.

## Timing
- pix_on is valid 1 cycle after pix_x/pix_y/pix_valid.
- hit_ok, miss, spawn_drop and score are registered and update on the edge that samples the stimulus.
- Slot changes show in pix_on starting with the pixel sampled on the cycle after the tick.
- frame_tick is to be driven during vertical blank so a frame is never torn.
- reset mid-operation clears state asynchronously. Release is synchronous to board_clk.

## Configuration
- NOTE_HIGHWAY_SCORE_EN defined: hit judging, hit_ok, press-miss and score behave as above.
- NOTE_HIGHWAY_SCORE_EN undefined: hit_btn is ignored, hit_ok=0 and score=0 constantly. miss pulses only on retirement. Scrolling, spawning and pixel output are unchanged.

## Test plan
- Pattern entry 0 = 3'b101, beat_tick → lanes 0 and 2 slot 0 valid at y=0, pat_idx=1. With pix_x=10, pix_y=5, pix_on=3'b001 one cycle later. With pix_y=11, pix_on=0.
- Lane 0 note at y=0, 480 frame_ticks at STEP=1 → retired on the 480th tick with a single miss[0] pulse and the slot freed.
- Note at y=390, hit_btn[0] → hit_ok[0], score 0→1, slot cleared. Same press with the note at y=417 → miss[0], score unchanged. Press at score=255 with a match → score stays 255.
- Pattern 3'b001 in all entries, 5 beat_ticks without frame_tick → slots 0-3 filled, 5th beat pulses spawn_drop, pat_idx=5. Then 8 more beats → pat_idx wraps to 5.
- Same cycle: hit on the slot at y=HIT_Y, frame_tick, beat_tick with lane full → hit clears that slot, others advance, spawn_drop pulses because the freed slot is not reused that cycle.
- restart asserted mid-game → all slots invalid, score=0, pat_idx=0. Pattern RAM contents survive. Async reset pulse mid-frame → pix_on=0 immediately.
